seg7_scan_ctrl: RTL

Time-multiplexed scan controller for the board's 8-digit common-anode seven-segment display. It takes a 32-bit value (eight hex nibbles) and a per-digit enable mask. It cycles through the AN[7:0] anodes one at a time and drives the matching active-low segment pattern on hex[6:0]. New values are shadowed and applied only on a frame boundary, so the display never tears. A blanking gap at the start of every digit slot suppresses ghosting.

---
 rtl/seg7_scan_if.sv | 27 ++
 rtl/seg7_scan_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_if.sv
// Bundle of the display value/strobe/mask inputs and the registered scan
// outputs of seg7_scan_ctrl.
//   value      : 32-bit display value, nibble i on digit i
//   load       : single-cycle strobe capturing value into the pending register
//   digit_en   : per-digit enable mask, sampled live
//   hex        : active-low segments {g,f,e,d,c,b,a}
//   AN         : active-low anodes, at most one low
//   frame_done : one-cycle pulse at the start of every new frame
// master = the client driving the value, slave = the scan controller.
interface seg7_scan_if;
    logic [31:0] value;
    logic        load;
    logic [7:0]  digit_en;
    logic [6:0]  hex;
    logic [7:0]  AN;
    logic        frame_done;

    modport master (
        output value, load, digit_en,
        input  hex, AN, frame_done
    );

    modport slave (
        input  value, load, digit_en,
        output hex, AN, frame_done
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode seven-segment
// display. Each digit owns a slot of PRESCALE clocks; the first BLANK_CYC
// clocks of every slot are dark to suppress ghosting. New values land in a
// pending register and are copied to the display register only at the frame
// boundary (slot 7 ending), so a frame never shows a mix of old and new.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : seg7_scan_if.slave (value, load, digit_en in; hex, AN, frame_done out)
//
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN
//   When defined, digits whose nibble and all higher nibbles are zero are
//   suppressed (digit 0 always shows). When undefined no logic is generated.
module seg7_scan_ctrl #(
    parameter int unsigned PRESCALE  = 1000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    seg7_scan_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    // Slot phase, tracks (counter >= BLANK_CYC)
    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    localparam logic [7:0] AN_OFF  = 8'hFF;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [0:0]       state_q, state_d;
    logic [31:0]      display_q, display_d;
    logic [31:0]      pending_q, pending_d;
    logic             pend_vld_q, pend_vld_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       hex_q, hex_d;
    logic             frame_done_q, frame_done_d;

    logic             cnt_wrap_c;
    logic             frame_bnd_c;
    logic [3:0]       nibble_c;
    logic [7:0]       lz_keep_c;
    logic             digit_on_c;

    // Active-low gfedcba segment patterns for hex digits 0..F
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    assign cnt_wrap_c  = (cnt_q == CNT_LAST);
    assign frame_bnd_c = cnt_wrap_c && (idx_q == 3'd7);
    assign nibble_c    = 4'(display_q >> {idx_q, 2'b00});

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Digit i stays lit only if some nibble at index >= i is nonzero
    always_comb begin
        lz_keep_c    = 8'h00;
        lz_keep_c[0] = 1'b1;
        for (int i = 1; i < 8; i++) begin
            lz_keep_c[i] = ((display_q >> (4 * i)) != 32'd0);
        end
    end
`else
    assign lz_keep_c = 8'hFF;
`endif

    assign digit_on_c = bus.digit_en[idx_q] & lz_keep_c[idx_q];

    // Prescale counter and digit index; 3-bit index wraps 7 -> 0 naturally
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_wrap_c) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end
    end

    // Slot FSM next-state and registered scan outputs
    always_comb begin
        state_d = state_q;
        an_d    = AN_OFF;
        hex_d   = SEG_OFF;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (digit_on_c) begin
                    an_d  = ~(8'd1 << idx_q);
                    hex_d = seg_decode(nibble_c);
                end
                if (cnt_wrap_c) begin
                    state_d = ST_BLANK;
                end
            end
            default: state_d = ST_BLANK;
        endcase
    end

    // Shadow registers: a load at the boundary bypasses the pending stage
    always_comb begin
        pending_d    = pending_q;
        pend_vld_d   = pend_vld_q;
        display_d    = display_q;
        frame_done_d = frame_bnd_c;
        if (bus.load) begin
            pending_d  = bus.value;
            pend_vld_d = 1'b1;
        end
        if (frame_bnd_c) begin
            pend_vld_d = 1'b0;
            if (bus.load) begin
                display_d = bus.value;
            end else if (pend_vld_q) begin
                display_d = pending_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            state_q      <= ST_BLANK;
            display_q    <= 32'd0;
            pending_q    <= 32'd0;
            pend_vld_q   <= 1'b0;
            an_q         <= AN_OFF;
            hex_q        <= SEG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            display_q    <= display_d;
            pending_q    <= pending_d;
            pend_vld_q   <= pend_vld_d;
            an_q         <= an_d;
            hex_q        <= hex_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.AN         = an_q;
    assign bus.hex        = hex_q;
    assign bus.frame_done = frame_done_q;

endmodule
